mcycle_unit: RTL and testbench

Multi-cycle multiply/divide responder on the processor's execute stage. Accepts a start request and operation code from the instruction decoder (01 = multiply, 10 = divide), computes an unsigned result iteratively over WIDTH cycles, and holds Busy high so the datapath stalls. Results are written back through the normal register-write path once Busy drops.

---
 rtl/mcycle_unit_pkg.sv | 20 ++
 rtl/mcycle_unit.sv | 78 +++++++
 tb/tb_mcycle_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mcycle_unit_pkg.sv
// mcycle_unit_pkg: shared op encodings and FSM state type for the multi-cycle unit
package mcycle_unit_pkg;

   typedef enum logic [1:0] {
      MCOP_NONE = 2'b00,
      MCOP_MUL  = 2'b01,
      MCOP_DIV  = 2'b10
   } mcop_t;

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      COMPUTING = 2'b01,
      DONE      = 2'b10
   } state_t;

   function automatic logic mcop_valid(input logic [1:0] op);
      return op == MCOP_MUL || op == MCOP_DIV;
   endfunction

endpackage

// File: rtl/mcycle_unit.sv
// mcycle_unit: iterative unsigned multiply/divide sharing one shift register and one adder
module mcycle_unit
   import mcycle_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             Start,
   input  logic [1:0]       MCOp,
   input  logic [WIDTH-1:0] Operand1,
   input  logic [WIDTH-1:0] Operand2,
   output logic [WIDTH-1:0] Result1,
   output logic [WIDTH-1:0] Result2,
   output logic             Busy
);

   localparam int CW = $clog2(WIDTH);

   state_t             state;
   logic [CW-1:0]      cnt;
   logic               op_div;
   logic [WIDTH-1:0]   b;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_nxt;
   logic [WIDTH:0]     rem;
   logic [WIDTH:0]     sum;

   assign Busy = (state == IDLE && Start && mcop_valid(MCOp)) || state == COMPUTING;

   // divide: partial remainder with the next dividend bit shifted in
   assign rem = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};

   // one adder/subtractor: add multiplicand to the high word, or trial-subtract the divisor
   assign sum = op_div ? rem - {1'b0, b} : {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, b};

   // next accumulator: shift right with conditional add, or shift left with restoring subtract
   always_comb begin
      acc_nxt = op_div ? (sum[WIDTH] ? {rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                     : {sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
                       : (acc[0] ? {sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]});
   end

   // control FSM, operand latch, iteration and result registers
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state   <= IDLE;
         cnt     <= '0;
         op_div  <= 1'b0;
         b       <= '0;
         acc     <= '0;
         Result1 <= '0;
         Result2 <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (Start && mcop_valid(MCOp)) begin
                  state  <= COMPUTING;
                  cnt    <= '0;
                  op_div <= MCOp == MCOP_DIV;
                  b      <= Operand2;
                  acc    <= {{WIDTH{1'b0}}, Operand1};
               end
            end
            COMPUTING: begin
               acc <= acc_nxt;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  state              <= DONE;
                  {Result2, Result1} <= acc_nxt;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mcycle_unit.sv
// tb_mcycle_unit: directed checks of multiply, divide, timing, back-to-back issue and reset
module tb_mcycle_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  mcop = 2'b00;
   logic [31:0] op1 = '0;
   logic [31:0] op2 = '0;
   logic [31:0] r1;
   logic [31:0] r2;
   logic        busy;
   int          total = 0;
   int          bad = 0;

   mcycle_unit #(.WIDTH(32)) dut (
      .CLK(clk), .RESET(rst), .Start(start), .MCOp(mcop),
      .Operand1(op1), .Operand2(op2), .Result1(r1), .Result2(r2), .Busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // issue at the current cycle, count busy cycles until DONE (bounded)
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] bb,
                        input bit scramble, output int nb, output logic [31:0] pre);
      start = 1'b1; mcop = op; op1 = a; op2 = bb; nb = 0; pre = '0;
      #1;
      while (busy && nb < 100) begin
         nb++;
         pre = r1;
         step();
         start = 1'b0;
         if (scramble) begin
            op1 = $urandom;
            op2 = $urandom;
         end
         #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (r1 !== 32'd0) begin bad++; $display("FAIL reset_r1 got=%h exp=0", r1); end
      total++; if (r2 !== 32'd0) begin bad++; $display("FAIL reset_r2 got=%h exp=0", r2); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_mul();
      int nb;
      logic [31:0] pre;
      do_op(2'b01, 32'd7, 32'd6, 1'b0, nb, pre);
      total++; if (nb != 33) begin bad++; $display("FAIL mul_busy_cycles got=%0d exp=33", nb); end
      total++; if (pre !== 32'd0) begin bad++; $display("FAIL mul_no_partial got=%h exp=0", pre); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mul_done_busy got=%b exp=0", busy); end
      total++; if (r1 !== 32'd42) begin bad++; $display("FAIL mul_7x6_lo got=%h exp=2a", r1); end
      total++; if (r2 !== 32'd0) begin bad++; $display("FAIL mul_7x6_hi got=%h exp=0", r2); end
      step();
      do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, nb, pre);
      total++; if (pre !== 32'd42) begin bad++; $display("FAIL mul_hold_prev got=%h exp=2a", pre); end
      total++; if (r1 !== 32'h0000_0001) begin bad++; $display("FAIL mul_max_lo got=%h exp=00000001", r1); end
      total++; if (r2 !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mul_max_hi got=%h exp=fffffffe", r2); end
      step();
   endtask

   task automatic test_div();
      int nb;
      logic [31:0] pre;
      do_op(2'b10, 32'd100, 32'd7, 1'b1, nb, pre);
      op1 = '0; op2 = '0;
      total++; if (nb != 33) begin bad++; $display("FAIL div_busy_cycles got=%0d exp=33", nb); end
      total++; if (r1 !== 32'd14) begin bad++; $display("FAIL div_100_7_q got=%h exp=e", r1); end
      total++; if (r2 !== 32'd2) begin bad++; $display("FAIL div_100_7_r got=%h exp=2", r2); end
      step();
      do_op(2'b10, 32'hFFFF_FFFF, 32'h10, 1'b0, nb, pre);
      total++; if (r1 !== 32'h0FFF_FFFF) begin bad++; $display("FAIL div_big_q got=%h exp=0fffffff", r1); end
      total++; if (r2 !== 32'hF) begin bad++; $display("FAIL div_big_r got=%h exp=f", r2); end
      step();
      do_op(2'b10, 32'd7, 32'd100, 1'b0, nb, pre);
      total++; if (r1 !== 32'd0) begin bad++; $display("FAIL div_small_q got=%h exp=0", r1); end
      total++; if (r2 !== 32'd7) begin bad++; $display("FAIL div_small_r got=%h exp=7", r2); end
      step();
   endtask

   task automatic test_div_zero();
      int nb;
      logic [31:0] pre;
      do_op(2'b10, 32'd5, 32'd0, 1'b0, nb, pre);
      total++; if (nb != 33) begin bad++; $display("FAIL divz_busy_cycles got=%0d exp=33", nb); end
      total++; if (r1 !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divz_q got=%h exp=ffffffff", r1); end
      total++; if (r2 !== 32'd5) begin bad++; $display("FAIL divz_r got=%h exp=5", r2); end
      step();
   endtask

   task automatic test_back_to_back();
      int n;
      start = 1'b1; mcop = 2'b01; op1 = 32'd3; op2 = 32'd4;
      #1;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept_busy got=%b exp=1", busy); end
      for (int i = 0; i < 33; i++) step();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_done_busy got=%b exp=0", busy); end
      total++; if (r1 !== 32'd12) begin bad++; $display("FAIL b2b_first got=%h exp=c", r1); end
      op1 = 32'd5;
      step();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_reaccept_busy got=%b exp=1", busy); end
      step();
      start = 1'b0;
      n = 0;
      #1;
      while (busy && n < 100) begin n++; step(); end
      total++; if (n != 32) begin bad++; $display("FAIL b2b_second_cycles got=%0d exp=32", n); end
      total++; if (r1 !== 32'd20) begin bad++; $display("FAIL b2b_second got=%h exp=14", r1); end
      step();
   endtask

   task automatic test_invalid_op();
      start = 1'b1; mcop = 2'b00; op1 = 32'd9; op2 = 32'd9;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL nop00_busy got=%b exp=0", busy); end
      step();
      mcop = 2'b11;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL nop11_busy got=%b exp=0", busy); end
      step();
      step();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL nop_later_busy got=%b exp=0", busy); end
      total++; if (r1 !== 32'd20) begin bad++; $display("FAIL nop_r1_kept got=%h exp=14", r1); end
      total++; if (r2 !== 32'd0) begin bad++; $display("FAIL nop_r2_kept got=%h exp=0", r2); end
      start = 1'b0; mcop = 2'b00;
      step();
   endtask

   task automatic test_reset_mid_op();
      int nb;
      logic [31:0] pre;
      start = 1'b1; mcop = 2'b10; op1 = 32'd1000; op2 = 32'd3;
      step();
      start = 1'b0;
      for (int i = 1; i < 10; i++) step();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
      #2;
      rst = 1'b1;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
      total++; if (r1 !== 32'd0) begin bad++; $display("FAIL mid_reset_r1 got=%h exp=0", r1); end
      total++; if (r2 !== 32'd0) begin bad++; $display("FAIL mid_reset_r2 got=%h exp=0", r2); end
      step();
      step();
      rst = 1'b0;
      step();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
      do_op(2'b01, 32'd3, 32'd3, 1'b0, nb, pre);
      total++; if (nb != 33) begin bad++; $display("FAIL post_reset_cycles got=%0d exp=33", nb); end
      total++; if (r1 !== 32'd9) begin bad++; $display("FAIL post_reset_3x3 got=%h exp=9", r1); end
      step();
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_div_zero();
      test_back_to_back();
      test_invalid_op();
      test_reset_mid_op();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
